// File: rtl/sr_drive_seq.sv
// sr_drive_seq: non-overlapping SR latch pulse driver; define SR_FB_CHECK_EN to verify q_fb/qb_fb after each command
module sr_drive_seq #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4,
  parameter int CHK_TO  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qb_fb,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;
  state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic r_level, w_level_n, w_s_n, w_r_n, w_done_n, w_err_n, w_end;
`ifndef SR_FB_CHECK_EN
  logic w_unused;
  assign w_unused = q_fb ^ qb_fb;
`endif
  // next state, counter and next registered outputs; s/r only ever come from one level bit so they cannot overlap
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_level_n = r_level;
    w_s_n     = 1'b0;
    w_r_n     = 1'b0;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_end     = 1'b0;
    case (r_state)
      IDLE: if (req_valid && req_ready) begin
        w_state_n = PULSE;
        w_cnt_n   = CNT_W'(PULSE_W - 1);
        w_level_n = req_level;
        w_s_n     = req_level;
        w_r_n     = ~req_level;
      end
      PULSE: if (r_cnt != '0) begin
        w_cnt_n = r_cnt - 1'b1;
        w_s_n   = r_level;
        w_r_n   = ~r_level;
      end else if (GAP_W != 0) begin
        w_state_n = GAP;
        w_cnt_n   = CNT_W'(GAP_W - 1);
      end else begin
        w_end = 1'b1;
      end
      GAP: if (r_cnt != '0) w_cnt_n = r_cnt - 1'b1;
      else w_end = 1'b1;
`ifdef SR_FB_CHECK_EN
      CHECK: if (q_fb == r_level && qb_fb == ~r_level) begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
      end else if (r_cnt == '0) begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
        w_err_n   = 1'b1;
      end else begin
        w_cnt_n = r_cnt - 1'b1;
      end
`endif
      default: w_state_n = IDLE;
    endcase
    if (w_end) begin
`ifdef SR_FB_CHECK_EN
      w_state_n = CHECK;
      w_cnt_n   = CNT_W'(CHK_TO - 1);
`else
      w_state_n = IDLE;
      w_done_n  = 1'b1;
`endif
    end
  end
  // state and all outputs are registered; reset aborts any command without a done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_level   <= w_level_n;
      s         <= w_s_n;
      r         <= w_r_n;
      req_ready <= w_state_n == IDLE;
      busy      <= w_state_n != IDLE;
      done      <= w_done_n;
      err       <= w_err_n;
    end
  end
endmodule

// File: doc/sr_drive_seq.md
Name: sr_drive_seq

Overview:
- Initiator side for an SR latch: turns level requests (target q value) into clean, non-overlapping set/reset pulses on s/r.
- Guarantees s and r are never both high, enforces a minimum pulse width and an inter-command gap, and optionally verifies latch feedback.
- Sits between control logic (valid/ready request interface) and any SR latch instance in the design.

Parameters:
- PULSE_W, 2, cycles s or r is held high per command (1..2^CNT_W-1)
- GAP_W, 1, idle cycles with s=r=0 after each pulse before the next command is accepted (0 allowed)
- CNT_W, 4, width of the internal pulse/gap/timeout counter
- CHK_TO, 3, cycles allowed for feedback to match after the pulse ends (used only with SR_FB_CHECK_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_level  in  1  target latch state: 1 = set, 0 = reset
- req_ready  out  1  block can accept a request this cycle
- s  out  1  set drive to latch
- r  out  1  reset drive to latch
- q_fb  in  1  latch q feedback
- qb_fb  in  1  latch qb feedback
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse: command finished
- err  out  1  one-cycle pulse with done: feedback check failed

Behaviour:
- Clocking: one clock domain (clk); reset synchronous, active-high (rst).
- Reset: s=0, r=0, req_ready=0 in the rst cycle then 1 from IDLE, busy=0, done=0, err=0, counter=0, state=IDLE. rst mid-pulse drops s/r to 0 on the next edge; no done is issued for the aborted command.
- All outputs registered; s and r are never 1 in the same cycle under any input sequence.
- States: IDLE, PULSE, GAP, CHECK.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_level and load counter=PULSE_W-1 -> PULSE. s=req_level, r=~req_level take effect on the same edge, so the first pulse cycle is the cycle after the handshake.
- PULSE: hold the drive; decrement counter; at 0 -> drive s=r=0, go to GAP (load GAP_W-1) or, if GAP_W=0, go directly to CHECK/completion. Pulse length is exactly PULSE_W cycles.
- GAP: s=r=0; decrement; at 0 -> CHECK (feature on) or complete.
- Completion: done=1 for one cycle; state returns to IDLE on the same edge; req_ready=1 in the following cycle.
- req_ready=0 in every non-IDLE state. req_valid and req_level are ignored while not ready; there is no queuing.
- Redundant request (target equals current feedback) still issues the full pulse.
- Back-to-back throughput: 1 + PULSE_W + GAP_W (+ check cycles) cycles per command.
- req_valid held high continuously: the next command is accepted on the first IDLE cycle.

Optional Feature:
- SR_FB_CHECK_EN defined: CHECK state samples q_fb/qb_fb each cycle. Match (q_fb==level && qb_fb==~level) -> done=1, err=0. No match within CHK_TO cycles -> done=1, err=1. Either way, return to IDLE.
- SR_FB_CHECK_EN not defined: no CHECK state; done is issued at the end of GAP (or PULSE if GAP_W=0); err is tied to 0; q_fb/qb_fb are unused.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> s=r=0, busy=0, done=0; req_ready=1 the cycle after rst falls.
- Set command, defaults: req_valid=1, req_level=1 at cycle T -> s=1 at T+1..T+2, r=0 throughout, s=r=0 at T+3 (gap), done at T+4 (feature off) with err=0.
- Back-to-back set then reset, req_valid held high -> second handshake on the first IDLE cycle; r pulses for 2 cycles; s and r are never high together in any cycle.
- Feature on, feedback stuck (q_fb=0, qb_fb=1) on a set request -> after CHK_TO=3 check cycles, done=1 and err=1 in the same cycle; then IDLE.
- Feature on, model latch with 1-cycle delay -> done=1, err=0 on the first matching check cycle.
- Reset mid-pulse: rst asserted on the second cycle of s=1 -> s=0 on the next edge, no done, busy=0, then a fresh request is accepted normally.
